f_sweep: RTL and testbench

Sequential exhaustive-stimulus and compare stage for the GATES exercises. On `start` it drives every combination of an N-bit input vector into two implementations of the same Boolean function: a gate-level module and an expression-level module. It captures both outputs for each vector and builds their truth tables. It then counts disagreements and reports the first failing minterm. It sits directly upstream of the function modules, feeding their inputs, and directly downstream of them, consuming their outputs. This replaces hand-written `#1` stimulus sequences with a clocked, self-checking sweep.

---
 rtl/gates_pkg.sv | 32 +++
 rtl/f_sweep_if.sv | 43 ++++
 rtl/sweep_cmp.sv | 68 ++++++
 rtl/f_sweep.sv | 123 ++++++++++++
 tb/tb_f_sweep.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/gates_pkg.sv
// Shared definitions for the GATES exercise sweep stage.
//   - sweep_state_e : state enum of the exhaustive sweep (IDLE/APPLY/SAMPLE/DONE)
//   - DEFAULT_N / DEFAULT_SETTLE : default parameter values
//   - N_MIN..N_MAX, SETTLE_MIN..SETTLE_MAX : legal parameter ranges
//   - CNT_W : width of the settle counter, sized for SETTLE_MAX
//   - param_ok() : helper that reports whether a parameter pair is legal
package gates_pkg;

  typedef enum logic [1:0] {
    SWEEP_IDLE   = 2'd0,
    SWEEP_APPLY  = 2'd1,
    SWEEP_SAMPLE = 2'd2,
    SWEEP_DONE   = 2'd3
  } sweep_state_e;

  localparam int DEFAULT_N      = 2;
  localparam int DEFAULT_SETTLE = 1;

  localparam int N_MIN      = 1;
  localparam int N_MAX      = 4;
  localparam int SETTLE_MIN = 1;
  localparam int SETTLE_MAX = 15;

  // Counter only ever holds 0..SETTLE-1, so 4 bits cover SETTLE_MAX.
  localparam int CNT_W = 4;

  function automatic bit param_ok(input int n, input int settle);
    return (n >= N_MIN) && (n <= N_MAX) &&
           (settle >= SETTLE_MIN) && (settle <= SETTLE_MAX);
  endfunction

endpackage

// File: rtl/f_sweep_if.sv
// Bus between the sweep stage and its environment (requester plus the two
// function implementations under comparison).
//
// Handshake: the requester raises `start`; it is taken only while the
// sweep stage is idle (busy=0, done=0). From the accepting edge `busy` is
// high until the final sample, then `done` pulses for exactly one cycle.
// `start` seen while busy or during the done cycle is dropped, never queued.
// Result fields are stable from the done cycle until the next accepted start.
//
// Signals:
//   start          requester -> sweep  request a sweep
//   x              sweep -> functions  stimulus vector (bit 0 = last input)
//   a, b           functions -> sweep  gate-level / expression-level outputs
//   busy, done     sweep -> requester  progress / completion pulse
//   tt_a, tt_b     sweep -> requester  captured truth tables (bit k = minterm k)
//   mismatch_count sweep -> requester  number of minterms with a != b
//   first_fail     sweep -> requester  lowest failing minterm (valid if fail_seen)
//   fail_seen      sweep -> requester  at least one mismatch in last sweep
interface f_sweep_if #(
  parameter int N = gates_pkg::DEFAULT_N
);
  logic              start;
  logic [N-1:0]      x;
  logic              a;
  logic              b;
  logic              busy;
  logic              done;
  logic [2**N-1:0]   tt_a;
  logic [2**N-1:0]   tt_b;
  logic [N:0]        mismatch_count;
  logic [N-1:0]      first_fail;
  logic              fail_seen;

  modport master (
    output start, a, b,
    input  x, busy, done, tt_a, tt_b, mismatch_count, first_fail, fail_seen
  );

  modport slave (
    input  start, a, b,
    output x, busy, done, tt_a, tt_b, mismatch_count, first_fail, fail_seen
  );
endinterface

// File: rtl/sweep_cmp.sv
// Per-sample comparator/accumulator for the sweep stage. On each sample
// strobe it compares the two implementation outputs and keeps the running
// mismatch count and the first failing minterm. `clear_i` wipes the
// results at the start of a sweep.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   clear_i             zero all results (sweep accepted)
//   sample_i            compare a_i/b_i for minterm x_i this cycle
//   a_i, b_i, x_i       sampled outputs and the minterm they belong to
//   mismatch_count_o    number of failing minterms (N+1 bits, holds 2^N)
//   first_fail_o        lowest failing minterm
//   fail_seen_o         any failure since the last clear
module sweep_cmp #(
  parameter int N = gates_pkg::DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_i,
  input  logic         sample_i,
  input  logic         a_i,
  input  logic         b_i,
  input  logic [N-1:0] x_i,
  output logic [N:0]   mismatch_count_o,
  output logic [N-1:0] first_fail_o,
  output logic         fail_seen_o
);
  import gates_pkg::*;

  logic [N:0]   mismatch_count_q, mismatch_count_d;
  logic [N-1:0] first_fail_q, first_fail_d;
  logic         fail_seen_q, fail_seen_d;

  always_comb begin
    mismatch_count_d = mismatch_count_q;
    first_fail_d     = first_fail_q;
    fail_seen_d      = fail_seen_q;
    if (clear_i) begin
      mismatch_count_d = '0;
      first_fail_d     = '0;
      fail_seen_d      = 1'b0;
    end else if (sample_i && (a_i != b_i)) begin
      mismatch_count_d = mismatch_count_q + (N+1)'(1);
      // Minterms are visited in ascending order, so the first hit is the lowest.
      if (!fail_seen_q) begin
        first_fail_d = x_i;
        fail_seen_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_count_q <= '0;
      first_fail_q     <= '0;
      fail_seen_q      <= 1'b0;
    end else begin
      mismatch_count_q <= mismatch_count_d;
      first_fail_q     <= first_fail_d;
      fail_seen_q      <= fail_seen_d;
    end
  end

  assign mismatch_count_o = mismatch_count_q;
  assign first_fail_o     = first_fail_q;
  assign fail_seen_o      = fail_seen_q;

endmodule

// File: rtl/f_sweep.sv
// Exhaustive stimulus-and-compare stage. On an accepted start it walks x
// through every N-bit vector, holds each for SETTLE cycles, samples both
// implementation outputs into truth tables and hands the comparison to
// sweep_cmp. Sweep ends at the all-ones vector, then pulses done.
//
// Ports:
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   bus          f_sweep_if slave: start/a/b in, x/busy/done/results out
//   dbg_state_o  current FSM state (gates_pkg::sweep_state_e encoding)
module f_sweep #(
  parameter int N      = gates_pkg::DEFAULT_N,
  parameter int SETTLE = gates_pkg::DEFAULT_SETTLE
) (
  input  logic         clk,
  input  logic         rst_n,
  f_sweep_if.slave     bus,
  output logic [1:0]   dbg_state_o
);
  import gates_pkg::*;

  localparam logic [1:0] S_IDLE   = SWEEP_IDLE;
  localparam logic [1:0] S_APPLY  = SWEEP_APPLY;
  localparam logic [1:0] S_SAMPLE = SWEEP_SAMPLE;
  localparam logic [1:0] S_DONE   = SWEEP_DONE;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [N-1:0]     X_LAST   = '1;
  localparam int               TT_W     = 2**N;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     x_q, x_d;
  logic [TT_W-1:0]  tt_a_q, tt_a_d;
  logic [TT_W-1:0]  tt_b_q, tt_b_d;
  logic             clear;
  logic             sample;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    tt_a_d  = tt_a_q;
    tt_b_d  = tt_b_q;
    clear   = 1'b0;
    sample  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          x_d     = '0;
          cnt_d   = '0;
          tt_a_d  = '0;
          tt_b_d  = '0;
          clear   = 1'b1;
          state_d = S_APPLY;
        end
      end
      S_APPLY: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SAMPLE: begin
        sample       = 1'b1;
        tt_a_d[x_q]  = bus.a;
        tt_b_d[x_q]  = bus.b;
        if (x_q == X_LAST) begin
          // Last vector: x stays at all-ones so results read back cleanly.
          state_d = S_DONE;
        end else begin
          x_d     = x_q + N'(1);
          cnt_d   = '0;
          state_d = S_APPLY;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      tt_a_q  <= '0;
      tt_b_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      tt_a_q  <= tt_a_d;
      tt_b_q  <= tt_b_d;
    end
  end

  sweep_cmp #(.N(N)) u_cmp (
    .clk              (clk),
    .rst_n            (rst_n),
    .clear_i          (clear),
    .sample_i         (sample),
    .a_i              (bus.a),
    .b_i              (bus.b),
    .x_i              (x_q),
    .mismatch_count_o (bus.mismatch_count),
    .first_fail_o     (bus.first_fail),
    .fail_seen_o      (bus.fail_seen)
  );

  assign bus.x       = x_q;
  assign bus.busy    = (state_q == S_APPLY) || (state_q == S_SAMPLE);
  assign bus.done    = (state_q == S_DONE);
  assign bus.tt_a    = tt_a_q;
  assign bus.tt_b    = tt_b_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_f_sweep.sv
// Bench for f_sweep: two instances (N=2/SETTLE=1 and N=3/SETTLE=3) fed by
// truth-table-defined functions; expectations come from the tables directly.
module tb_f_sweep;
  import gates_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  f_sweep_if #(.N(2)) if2();
  f_sweep_if #(.N(3)) if3();
  logic [1:0] dbg2, dbg3;

  f_sweep #(.N(2), .SETTLE(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2), .dbg_state_o(dbg2));
  f_sweep #(.N(3), .SETTLE(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3), .dbg_state_o(dbg3));

  // Functions under test are combinational lookups in bench-owned tables.
  logic [7:0] fa2 = '0, fb2 = '0, fa3 = '0, fb3 = '0;
  assign if2.a = fa2[if2.x];
  assign if2.b = fb2[if2.x];
  assign if3.a = fa3[if3.x];
  assign if3.b = fb3[if3.x];

  // Observation mux so one driver serves both instances.
  int sel = 0;
  logic [31:0] o_busy, o_done, o_x, o_tta, o_ttb, o_mm, o_ff, o_fs, o_st;
  assign o_busy = (sel != 0) ? 32'(if3.busy)           : 32'(if2.busy);
  assign o_done = (sel != 0) ? 32'(if3.done)           : 32'(if2.done);
  assign o_x    = (sel != 0) ? 32'(if3.x)              : 32'(if2.x);
  assign o_tta  = (sel != 0) ? 32'(if3.tt_a)           : 32'(if2.tt_a);
  assign o_ttb  = (sel != 0) ? 32'(if3.tt_b)           : 32'(if2.tt_b);
  assign o_mm   = (sel != 0) ? 32'(if3.mismatch_count) : 32'(if2.mismatch_count);
  assign o_ff   = (sel != 0) ? 32'(if3.first_fail)     : 32'(if2.first_fail);
  assign o_fs   = (sel != 0) ? 32'(if3.fail_seen)      : 32'(if2.fail_seen);
  assign o_st   = (sel != 0) ? 32'(dbg3)               : 32'(dbg2);

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_start(input logic v);
    if (sel != 0) if3.start = v;
    else          if2.start = v;
  endtask

  // One full sweep against the reference model; noise injects start pulses while busy.
  task automatic run_sweep(input int s, input logic [7:0] fa, input logic [7:0] fb, input bit noise);
    int n, st, nv, exp_done, cyc, done_cyc, busy_cnt, x_bad, exp_mm, exp_ff;
    logic [7:0] mask, diff;
    sel = s;
    n   = (s != 0) ? 3 : 2;
    st  = (s != 0) ? 3 : 1;
    nv  = 1 << n;
    mask = 8'((1 << nv) - 1);
    exp_done = nv * (st + 1) + 1;
    diff = (fa ^ fb) & mask;
    exp_mm = 0;
    exp_ff = -1;
    for (int k = 0; k < nv; k++) begin
      if (diff[k]) begin
        exp_mm++;
        if (exp_ff < 0) exp_ff = k;
      end
    end

    @(negedge clk);
    if (s != 0) begin fa3 = fa; fb3 = fb; end
    else        begin fa2 = fa; fb2 = fb; end
    drive_start(1'b1);
    @(posedge clk); #1;
    drive_start(1'b0);
    check("start_busy", o_busy, 1);
    check("start_x", o_x, 0);

    cyc = 1; done_cyc = 0; busy_cnt = 0; x_bad = 0;
    while (done_cyc == 0 && cyc <= exp_done + 10) begin
      if (o_done[0]) begin
        done_cyc = cyc;
      end else begin
        if (o_busy[0]) busy_cnt++;
        if (o_x != 32'((cyc - 1) / (st + 1))) x_bad++;
        if (noise && cyc < exp_done - 1) drive_start(1'($urandom_range(0, 1)));
        else                             drive_start(1'b0);
        @(posedge clk); #1;
        cyc++;
      end
    end
    drive_start(1'b0);
    check("done_cycle", done_cyc, exp_done);
    check("busy_cycles", busy_cnt, exp_done - 1);
    check("busy_at_done", o_busy, 0);
    check("x_walk", x_bad, 0);
    check("x_final", o_x, nv - 1);
    check("tt_a", o_tta, 32'(fa & mask));
    check("tt_b", o_ttb, 32'(fb & mask));
    check("mismatch_count", o_mm, exp_mm);
    check("fail_seen", o_fs, (exp_mm != 0) ? 1 : 0);
    check("first_fail", o_ff, (exp_ff < 0) ? 0 : exp_ff);

    @(posedge clk); #1;
    check("done_pulse_end", o_done, 0);
    check("idle_busy", o_busy, 0);
    check("hold_tt_a", o_tta, 32'(fa & mask));
    check("hold_mm", o_mm, exp_mm);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_x"},    o_x, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_tta"},  o_tta, 0);
    check({tag, "_ttb"},  o_ttb, 0);
    check({tag, "_mm"},   o_mm, 0);
    check({tag, "_ff"},   o_ff, 0);
    check({tag, "_fs"},   o_fs, 0);
    check({tag, "_state"}, o_st, 32'(SWEEP_IDLE));
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  initial begin
    if2.start = 1'b0;
    if3.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sel = 0; check_all_zero("rst2");
    sel = 1; check_all_zero("rst3");
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Directed cases from the function pairs of interest.
    run_sweep(0, 8'b1000, 8'b1000, 1'b0);     // AND vs AND
    run_sweep(0, 8'b1000, 8'b0000, 1'b0);     // AND vs constant 0
    run_sweep(0, 8'b0110, 8'b0010, 1'b0);     // XOR vs ~x1&x0
    run_sweep(1, 8'b10010110, 8'b10010110, 1'b0); // 3-input parity
    run_sweep(0, 8'b1111, 8'b0000, 1'b1);     // every minterm fails

    // Abort mid-sweep with reset.
    sel = 0;
    @(negedge clk); fa2 = 8'b0101; fb2 = 8'b1010; if2.start = 1'b1;
    @(posedge clk); #1; if2.start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("pre_abort_busy", o_busy, 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("abort");
    #1 rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; check("post_abort_busy", o_busy, 0); end
    run_sweep(0, 8'b0101, 8'b1010, 1'b0);

    // Randomized tables on both instances, with start noise while busy.
    for (int i = 0; i < 8; i++) begin
      run_sweep(i % 2, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);
    end

    // start held high: sweeps repeat every sweep length plus one IDLE cycle.
    sel = 0;
    exp_q.delete(); got_q.delete();
    for (int c = 9; c <= 25; c += 10) exp_q.push_back(32'(c));
    @(negedge clk); fa2 = 8'b1000; fb2 = 8'b1000; if2.start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 25; c++) begin
      if (o_done[0]) got_q.push_back(32'(c));
      @(posedge clk); #1;
    end
    if2.start = 1'b0;
    check("held_done_count", got_q.size(), exp_q.size());
    while (exp_q.size() != 0 && got_q.size() != 0) begin
      check("held_done_cycle", got_q.pop_front(), exp_q.pop_front());
    end
    repeat (20) @(posedge clk);
    #1;
    check("held_end_busy", o_busy, 0);
    check("held_end_tt_a", o_tta, 32'b1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
